ofdm_ifft_cp_framer: RTL and testbench

- Parametrised successor of the team's IFFT modulator stage for the 802.22 TX chain.
- Accepts frequency-domain samples on a Wishbone-style write-stream input and forwards them to an external IFFT core over AXI-stream.
- Collects each natural-order IFFT output symbol in a ping-pong buffer.
- Emits cyclic prefix plus symbol body on a Wishbone-style output stream. CP length is runtime-selectable, replacing the fixed start-up delay counter.

---
 rtl/ofdm_tx_pkg.sv | 29 ++
 rtl/ofdm_ifft_cp_framer_if.sv | 60 ++++++
 rtl/ofdm_pingpong_ram.sv | 48 ++++
 rtl/ofdm_ifft_cp_framer.sv | 189 ++++++++++++++++++
 tb/tb_ofdm_ifft_cp_framer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM TX IFFT/CP framer: CP mode encodings,
// CP length helper and the output sequencer state type.
package ofdm_tx_pkg;

  localparam logic [1:0] CP_MODE_N4  = 2'd0;
  localparam logic [1:0] CP_MODE_N8  = 2'd1;
  localparam logic [1:0] CP_MODE_N16 = 2'd2;
  localparam logic [1:0] CP_MODE_N32 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } fsm_state_e;

  // CP length in samples; floors to zero when N is too small for the ratio.
  function automatic int unsigned cp_len(input logic [1:0] mode,
                                         input int unsigned nfft_log2);
    int unsigned shift;
    case (mode)
      CP_MODE_N4:  shift = 32'd2;
      CP_MODE_N8:  shift = 32'd3;
      CP_MODE_N16: shift = 32'd4;
      default:     shift = 32'd5;
    endcase
    return (32'd1 << nfft_log2) >> shift;
  endfunction

endpackage

// File: rtl/ofdm_ifft_cp_framer_if.sv
// Bus bundle of the IFFT/CP framer: Wishbone-style input and output streams,
// AXI-stream to/from the IFFT core, CP mode select and debug taps.
// SYM_CNT_EN adds the SYM_CNT_O symbol counter.
//
// Handshake rules: an input sample transfers in a cycle where ACK_O=1; an output
// sample transfers in a cycle where STB_O=1 and ACK_I=1, and STB_O/DAT_O hold
// while STB_O=1 and ACK_I=0; an IFFT_M beat transfers when TVALID and TREADY are
// both 1; IFFT_S_TVALID pulses for one cycle per sample already admitted by ACK_O.
interface ofdm_ifft_cp_framer_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) ();
  import ofdm_tx_pkg::*;

  logic [DW-1:0]    DAT_I;
  logic             CYC_I;
  logic             STB_I;
  logic             WE_I;
  logic             ACK_O;
  logic [DW-1:0]    DAT_O;
  logic             CYC_O;
  logic             STB_O;
  logic             WE_O;
  logic             ACK_I;
  logic [1:0]       CP_MODE_I;
  logic [DW-1:0]    IFFT_S_TDATA;
  logic             IFFT_S_TVALID;
  logic             IFFT_S_TREADY;
  logic [DW-1:0]    IFFT_M_TDATA;
  logic             IFFT_M_TVALID;
  logic             IFFT_M_TREADY;
`ifdef SYM_CNT_EN
  logic [CNT_W-1:0] SYM_CNT_O;
`endif
  fsm_state_e       dbg_state;
  logic [CNT_W-1:0] dbg_inflight;

  modport slave (
    input  DAT_I, CYC_I, STB_I, WE_I, ACK_I, CP_MODE_I,
    input  IFFT_S_TREADY, IFFT_M_TDATA, IFFT_M_TVALID,
    output ACK_O, DAT_O, CYC_O, STB_O, WE_O,
    output IFFT_S_TDATA, IFFT_S_TVALID, IFFT_M_TREADY,
`ifdef SYM_CNT_EN
    output SYM_CNT_O,
`endif
    output dbg_state, dbg_inflight
  );

  modport master (
    output DAT_I, CYC_I, STB_I, WE_I, ACK_I, CP_MODE_I,
    output IFFT_S_TREADY, IFFT_M_TDATA, IFFT_M_TVALID,
    input  ACK_O, DAT_O, CYC_O, STB_O, WE_O,
    input  IFFT_S_TDATA, IFFT_S_TVALID, IFFT_M_TREADY,
`ifdef SYM_CNT_EN
    input  SYM_CNT_O,
`endif
    input  dbg_state, dbg_inflight
  );

endinterface

// File: rtl/ofdm_pingpong_ram.sv
// Two-bank symbol buffer: simple dual-port synchronous RAM (1-cycle read
// latency) plus a full flag per bank with independent set and release.
module ofdm_pingpong_ram #(
  parameter int DW = 32,
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          set_full_i,
  input  logic          rel_i,
  input  logic          rel_bank_i,
  input  logic          rd_en_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic [1:0]    full_o
);

  logic [DW-1:0] mem_q [2**(AW+1)];
  logic [DW-1:0] rd_data_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
  end

  // Release and set target different banks in normal operation; both apply.
  always_comb begin
    full_d = full_q;
    if (rel_i)      full_d[rel_bank_i] = 1'b0;
    if (set_full_i) full_d[wr_bank_i]  = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) full_q <= 2'b00;
    else         full_q <= full_d;
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;

endmodule

// File: rtl/ofdm_ifft_cp_framer.sv
// IFFT modulator stage: feeds samples to an external IFFT core, buffers each
// output symbol in a ping-pong RAM and emits cyclic prefix + body.
// Optional SYM_CNT_EN macro adds the SYM_CNT_O completed-symbol counter.
module ofdm_ifft_cp_framer
  import ofdm_tx_pkg::*;
#(
  parameter int DW        = 32,
  parameter int NFFT_LOG2 = 11,
  parameter int CNT_W     = 16
) (
  input logic                    CLK_I,
  input logic                    RST_I,
  ofdm_ifft_cp_framer_if.slave   bus
);

  localparam int              AW        = NFFT_LOG2;
  localparam logic [AW-1:0]   LAST_ADDR = '1;

  // Input path
  logic             accept;
  logic [DW-1:0]    s_tdata_q;
  logic             s_tvalid_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;

  // Capture path
  logic [1:0]       full;
  logic             wr_bank_q;
  logic [AW-1:0]    wr_idx_q;
  logic             m_tready;
  logic             beat;
  logic             wr_last;

  // Output path
  fsm_state_e       state_q;
  logic             rd_bank_q;
  logic [AW-1:0]    rd_addr_q;
  logic             stb_q;
  logic             cyc_q;
  logic [DW-1:0]    rd_data;
  logic [AW-1:0]    cp_len_next;
  logic [AW-1:0]    cp_start;
  logic             cp_zero;
  logic             adv;
  logic             issue;
  logic             rd_last;
  logic             drain_done;

  // Reset also masks the combinational handshakes so every output is 0 in reset.
  assign accept = RST_I & bus.CYC_I & bus.STB_I & bus.WE_I & bus.IFFT_S_TREADY;

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !beat)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && beat) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      s_tdata_q  <= '0;
      s_tvalid_q <= 1'b0;
      inflight_q <= '0;
    end else begin
      s_tvalid_q <= accept;
      if (accept) s_tdata_q <= bus.DAT_I;
      inflight_q <= inflight_d;
    end
  end

  assign m_tready = RST_I & ~full[wr_bank_q];
  assign beat     = bus.IFFT_M_TVALID & m_tready;
  assign wr_last  = beat & (wr_idx_q == LAST_ADDR);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
    end else if (beat) begin
      wr_idx_q <= wr_idx_q + AW'(1);
      if (wr_last) wr_bank_q <= ~wr_bank_q;
    end
  end

  ofdm_pingpong_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk_i      (CLK_I),
    .rst_ni     (RST_I),
    .wr_en_i    (beat),
    .wr_bank_i  (wr_bank_q),
    .wr_addr_i  (wr_idx_q),
    .wr_data_i  (bus.IFFT_M_TDATA),
    .set_full_i (wr_last),
    .rel_i      (rd_last),
    .rel_bank_i (rd_bank_q),
    .rd_en_i    (issue),
    .rd_bank_i  (rd_bank_q),
    .rd_addr_i  (rd_addr_q),
    .rd_data_o  (rd_data),
    .full_o     (full)
  );

  // CP starts at N - cp_len, i.e. the two's complement of cp_len in AW bits.
  assign cp_len_next = AW'(cp_len(bus.CP_MODE_I, NFFT_LOG2));
  assign cp_start    = AW'(0) - cp_len_next;
  assign cp_zero     = (cp_len_next == '0);

  // The RAM read register doubles as the output data register.
  assign adv        = ~stb_q | bus.ACK_I;
  assign issue      = adv & (state_q != ST_IDLE);
  assign rd_last    = issue & (state_q == ST_BODY) & (rd_addr_q == LAST_ADDR);
  assign drain_done = ~bus.CYC_I & (inflight_q == '0) & (full == 2'b00) &
                      (state_q == ST_IDLE) & ~stb_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= ST_IDLE;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
    end else begin
      if (adv)        stb_q <= issue;
      if (drain_done) cyc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (full[rd_bank_q]) begin
            cyc_q     <= 1'b1;
            state_q   <= cp_zero ? ST_BODY : ST_CP;
            rd_addr_q <= cp_start;
          end
        end
        ST_CP: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q + AW'(1);
            if (rd_addr_q == LAST_ADDR) state_q <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q + AW'(1);
            if (rd_addr_q == LAST_ADDR) begin
              rd_bank_q <= ~rd_bank_q;
              // Chain straight into the next prefix when the other bank is ready.
              if (full[~rd_bank_q]) begin
                state_q   <= cp_zero ? ST_BODY : ST_CP;
                rd_addr_q <= cp_start;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SYM_CNT_EN
  logic             cyc_in_q;
  logic [CNT_W-1:0] sym_cnt_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cyc_in_q  <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      cyc_in_q <= bus.CYC_I;
      if (bus.CYC_I && !cyc_in_q) sym_cnt_q <= '0;
      else if (rd_last)           sym_cnt_q <= sym_cnt_q + CNT_W'(1);
    end
  end

  assign bus.SYM_CNT_O = sym_cnt_q;
`endif

  assign bus.ACK_O         = accept;
  assign bus.DAT_O         = rd_data & {DW{stb_q}};
  assign bus.STB_O         = stb_q;
  assign bus.WE_O          = stb_q;
  assign bus.CYC_O         = cyc_q;
  assign bus.IFFT_S_TDATA  = s_tdata_q;
  assign bus.IFFT_S_TVALID = s_tvalid_q;
  assign bus.IFFT_M_TREADY = m_tready;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_inflight  = inflight_q;

endmodule

// File: tb/tb_ofdm_ifft_cp_framer.sv
// Bench for ofdm_ifft_cp_framer with N=64 and an identity IFFT stub of 20-cycle
// latency; expected output is built per symbol as its last cp samples then all N.
module tb_ofdm_ifft_cp_framer;
  import ofdm_tx_pkg::*;

  localparam int DW         = 32;
  localparam int NFFT_LOG2  = 6;
  localparam int CNT_W      = 16;
  localparam int N          = 64;
  localparam int LAT        = 20;
  localparam int STUB_LIMIT = 24;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofdm_ifft_cp_framer_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  ofdm_ifft_cp_framer #(
    .DW        (DW),
    .NFFT_LOG2 (NFFT_LOG2),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .bus   (bus)
  );

  // Models and scoreboard
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stub_dq[$];
  int            stub_tq[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc_cnt = 0;
  int            ack_mode = 0;
  bit            ack_tgl = 1'b1;
  logic [1:0]    cp_mode_drv = 2'd0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  // Per-test statistics
  int            n_stb, n_hs, first_c, last_c;
  logic [DW-1:0] first_dat;
  bit            cyc_seen;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] base;
    int            exp_len;
    logic [DW-1:0] exp_first;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_stats();
    n_stb = 0; n_hs = 0; first_c = -1; last_c = 0; first_dat = '0; cyc_seen = 1'b0;
  endtask

  // Queue one symbol; reference output is the last cp samples followed by all N.
  task automatic feed_symbol(input logic [1:0] mode, input bit rnd, input logic [DW-1:0] base);
    logic [DW-1:0] sym[N];
    int cp;
    cp = N >> (int'(mode) + 2);
    for (int k = 0; k < N; k++) begin
      sym[k] = rnd ? DW'($urandom()) : base + DW'(k);
      src_q.push_back(sym[k]);
    end
    for (int k = N - cp; k < N; k++) exp_q.push_back(sym[k]);
    for (int k = 0; k < N; k++) exp_q.push_back(sym[k]);
  endtask

  // Driver + stub + monitor for one clock: drive at negedge, observe the
  // transfers that the following posedge will complete.
  task automatic tick();
    @(negedge clk);
    bus.CYC_I         = (src_q.size() > 0);
    bus.STB_I         = (src_q.size() > 0);
    bus.WE_I          = (src_q.size() > 0);
    bus.DAT_I         = (src_q.size() > 0) ? src_q[0] : '0;
    bus.CP_MODE_I     = cp_mode_drv;
    bus.IFFT_S_TREADY = (stub_dq.size() < STUB_LIMIT);
    if (stub_dq.size() > 0 && stub_tq[0] <= cyc_cnt) begin
      bus.IFFT_M_TVALID = 1'b1;
      bus.IFFT_M_TDATA  = stub_dq[0];
    end else begin
      bus.IFFT_M_TVALID = 1'b0;
      bus.IFFT_M_TDATA  = '0;
    end
    case (ack_mode)
      0: bus.ACK_I = 1'b1;
      1: begin bus.ACK_I = ack_tgl; ack_tgl = ~ack_tgl; end
      2: bus.ACK_I = ($urandom_range(0, 99) < 70);
      default: bus.ACK_I = 1'b0;
    endcase
    #1;
    if (bus.ACK_O) void'(src_q.pop_front());
    if (bus.IFFT_S_TVALID) begin
      stub_dq.push_back(bus.IFFT_S_TDATA);
      stub_tq.push_back(cyc_cnt + LAT);
    end
    if (bus.IFFT_M_TVALID && bus.IFFT_M_TREADY) begin
      void'(stub_dq.pop_front());
      void'(stub_tq.pop_front());
    end
    if (prev_stall) begin
      check("hold_stb", bus.STB_O, 1'b1);
      check("hold_dat", bus.DAT_O, prev_dat);
    end
    if (bus.STB_O) begin
      n_stb++;
      if (first_c < 0) first_c = cyc_cnt;
      last_c = cyc_cnt;
      cyc_seen = cyc_seen | bus.CYC_O;
    end
    if (bus.STB_O && bus.ACK_I) begin
      n_hs++;
      if (n_hs == 1) first_dat = bus.DAT_O;
      if (exp_q.size() == 0) begin
        check("dat_o_unexpected", bus.DAT_O, {DW{1'b1}} ^ bus.DAT_O);
      end else begin
        check("dat_o", bus.DAT_O, exp_q.pop_front());
      end
    end
    prev_stall = bus.STB_O & ~bus.ACK_I;
    prev_dat   = bus.DAT_O;
    cyc_cnt++;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0 || bus.STB_O) && c < budget) begin
      tick();
      c++;
    end
    check({name, "_left"}, exp_q.size(), 0);
    c = 0;
    while (bus.CYC_O && c < 20) begin
      tick();
      c++;
    end
    check({name, "_cyc_o_fall"}, bus.CYC_O, 1'b0);
  endtask

  task automatic idle_inputs();
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0; bus.DAT_I = '0;
    bus.ACK_I = 1'b0; bus.CP_MODE_I = 2'd0; bus.IFFT_S_TREADY = 1'b1;
    bus.IFFT_M_TVALID = 1'b0; bus.IFFT_M_TDATA = '0;
  endtask

  task automatic flush_models();
    src_q.delete(); exp_q.delete(); stub_dq.delete(); stub_tq.delete();
    prev_stall = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int nsym;
    logic [1:0] m;

    vecs[0] = '{2'd0, 32'h0000_1000, 80, 32'h0000_1030};
    vecs[1] = '{2'd1, 32'h0000_2000, 72, 32'h0000_2038};
    vecs[2] = '{2'd2, 32'h0000_3000, 68, 32'h0000_303C};
    vecs[3] = '{2'd3, 32'h0000_4000, 66, 32'h0000_403E};

    // Reset state, with the input strobes asserted to show ACK_O is masked
    idle_inputs();
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack_o", bus.ACK_O, 1'b0);
    check("rst_stb_o", bus.STB_O, 1'b0);
    check("rst_cyc_o", bus.CYC_O, 1'b0);
    check("rst_dat_o", bus.DAT_O, 0);
    check("rst_s_tvalid", bus.IFFT_S_TVALID, 1'b0);
    check("rst_m_tready", bus.IFFT_M_TREADY, 1'b0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one symbol per CP mode, full-rate sink
    for (int i = 0; i < 4; i++) begin
      start_stats();
      ack_mode = 0;
      cp_mode_drv = vecs[i].mode;
      feed_symbol(vecs[i].mode, 1'b0, vecs[i].base);
      wait_drain("vec", 400);
      check("vec_len", n_hs, vecs[i].exp_len);
      check("vec_span", last_c - first_c + 1, vecs[i].exp_len);
      check("vec_first", first_dat, vecs[i].exp_first);
      check("vec_cyc_o_high", cyc_seen, 1'b1);
    end

    // Three back-to-back symbols: contiguous STB_O
    start_stats();
    cp_mode_drv = 2'd0;
    for (int s = 0; s < 3; s++) feed_symbol(2'd0, 1'b1, '0);
    wait_drain("b2b", 1200);
    check("b2b_count", n_stb, 240);
    check("b2b_span", last_c - first_c + 1, 240);
`ifdef SYM_CNT_EN
    check("b2b_sym_cnt", bus.SYM_CNT_O, 3);
`endif

    // Sink alternating ACK_I 1,0
    start_stats();
    ack_mode = 1;
    cp_mode_drv = 2'd2;
    for (int s = 0; s < 2; s++) feed_symbol(2'd2, 1'b1, '0);
    wait_drain("toggle", 1000);
    check("toggle_count", n_hs, 136);

    // Sink stalled for 100 cycles during symbol 1 with 3 symbols queued
    start_stats();
    ack_mode = 0;
    cp_mode_drv = 2'd0;
    for (int s = 0; s < 3; s++) feed_symbol(2'd0, 1'b1, '0);
    c = 0;
    while (n_stb == 0 && c < 400) begin tick(); c++; end
    check("bp_started", n_stb > 0, 1'b1);
    ack_mode = 3;
    repeat (100) tick();
    check("bp_m_tready", bus.IFFT_M_TREADY, 1'b0);
    check("bp_ack_o", bus.ACK_O, 1'b0);
    check("bp_src_pending", src_q.size() > 0, 1'b1);
    ack_mode = 0;
    wait_drain("bp", 1500);
    check("bp_count", n_hs, 240);

    // CP mode changed mid-prefix: only the next symbol sees it
    start_stats();
    cp_mode_drv = 2'd3;
    feed_symbol(2'd3, 1'b1, '0);
    feed_symbol(2'd1, 1'b1, '0);
    c = 0;
    while (n_stb == 0 && c < 400) begin tick(); c++; end
    cp_mode_drv = 2'd1;
    wait_drain("cpsw", 800);
    check("cpsw_count", n_hs, 66 + 72);

    // Randomized batches with a random sink
    for (int b = 0; b < 3; b++) begin
      start_stats();
      ack_mode = 2;
      m = 2'($urandom_range(0, 3));
      nsym = $urandom_range(1, 3);
      cp_mode_drv = m;
      for (int s = 0; s < nsym; s++) feed_symbol(m, 1'b1, '0);
      wait_drain("rand", 2000);
      check("rand_count", n_hs, nsym * (N + (N >> (int'(m) + 2))));
    end

    // Asynchronous reset mid-body, then a clean symbol
    start_stats();
    ack_mode = 0;
    cp_mode_drv = 2'd0;
    feed_symbol(2'd0, 1'b1, '0);
    c = 0;
    while (n_hs < 30 && c < 400) begin tick(); c++; end
    check("rst_mid_body", n_hs >= 30, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b1; bus.IFFT_S_TREADY = 1'b1;
    #1;
    check("arst_stb_o", bus.STB_O, 1'b0);
    check("arst_cyc_o", bus.CYC_O, 1'b0);
    check("arst_ack_o", bus.ACK_O, 1'b0);
    check("arst_state", bus.dbg_state, ST_IDLE);
    flush_models();
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_stats();
    feed_symbol(2'd0, 1'b0, 32'h0000_5000);
    wait_drain("post_rst", 400);
    check("post_rst_first", first_dat, 32'h0000_5030);
    check("post_rst_len", n_hs, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
